pipe_ctrl_unit: RTL and testbench

Parametrised successor to the single-cycle main control decoder. It decodes the ID-stage opcode into the same control bundle, then carries that bundle through ID/EX, EX/MEM and MEM/WB pipeline registers. It also detects load-use hazards, inserts bubbles and applies jump/branch flushes. It sits beside the datapath pipeline registers and drives every stage's control inputs plus the PC and IF/ID write enables.

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_if.sv | 57 +++++
 rtl/pipe_ctrl_decode.sv | 63 ++++++
 rtl/pipe_ctrl_unit.sv | 106 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode and ALUOp encodings plus the per-stage control bundle types
// used by the pipelined main-control unit.
package pipe_ctrl_pkg;

  localparam int CTRL_ALUOP_W = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_XOR   = 2'b11;

  // Nested so each later pipeline register keeps only the fields it still needs.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic                    reg_dst;
    logic                    alu_src;
    logic                    sign_zero;
    logic [CTRL_ALUOP_W-1:0] alu_op;
    mem_ctrl_t               mem;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the datapath-facing signals of pipe_ctrl_unit; the slave modport is the
// control unit. Optional ILLEGAL_OP_TRAP_EN adds the sticky illegal_op_o flag.
interface pipe_ctrl_if #(
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int STALL_CNT_W = 16
) ();

  logic [OPCODE_W-1:0]    id_opcode_i;
  logic [REG_ADDR_W-1:0]  id_rs_i;
  logic [REG_ADDR_W-1:0]  id_rt_i;
  logic [REG_ADDR_W-1:0]  idex_rt_i;
  logic                   branch_taken_i;

  logic                   pc_write_o;
  logic                   ifid_write_o;
  logic                   ifid_flush_o;
  logic                   jump_o;
  logic                   ex_reg_dst_o;
  logic                   ex_alu_src_o;
  logic                   ex_sign_zero_o;
  logic [ALUOP_W-1:0]     ex_alu_op_o;
  logic                   ex_mem_read_o;
  logic                   mem_mem_read_o;
  logic                   mem_mem_write_o;
  logic                   mem_branch_o;
  logic                   wb_reg_write_o;
  logic                   wb_mem_to_reg_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                   illegal_op_o;
`endif

  modport master (
    output id_opcode_i, id_rs_i, id_rt_i, idex_rt_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, jump_o,
`ifdef ILLEGAL_OP_TRAP_EN
           illegal_op_o,
`endif
           ex_reg_dst_o, ex_alu_src_o, ex_sign_zero_o, ex_alu_op_o, ex_mem_read_o,
           mem_mem_read_o, mem_mem_write_o, mem_branch_o,
           wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o
  );

  modport slave (
    input  id_opcode_i, id_rs_i, id_rt_i, idex_rt_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, jump_o,
`ifdef ILLEGAL_OP_TRAP_EN
           illegal_op_o,
`endif
           ex_reg_dst_o, ex_alu_src_o, ex_sign_zero_o, ex_alu_op_o, ex_mem_read_o,
           mem_mem_read_o, mem_mem_write_o, mem_branch_o,
           wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational opcode-to-control-bundle table for the ID stage.
// With ILLEGAL_OP_TRAP_EN it also reports whether the opcode is a listed one.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_bundle_t        ctrl_o,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                legal_o,
`endif
  output logic                jump_o
);

  // Unlisted opcodes fall through to the default bundle: everything off, ALUOp=R-type.
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    jump_o = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    legal_o = 1'b1;
`endif
    case (opcode_i)
      OPCODE_W'(OP_RTYPE): begin
        ctrl_o.reg_dst          = 1'b1;
        ctrl_o.mem.wb.reg_write = 1'b1;
        ctrl_o.alu_op           = ALUOP_RTYPE;
      end
      OPCODE_W'(OP_LW): begin
        ctrl_o.alu_src           = 1'b1;
        ctrl_o.mem.mem_read      = 1'b1;
        ctrl_o.mem.wb.reg_write  = 1'b1;
        ctrl_o.mem.wb.mem_to_reg = 1'b1;
        ctrl_o.alu_op            = ALUOP_ADD;
      end
      OPCODE_W'(OP_SW): begin
        ctrl_o.alu_src       = 1'b1;
        ctrl_o.mem.mem_write = 1'b1;
        ctrl_o.alu_op        = ALUOP_ADD;
      end
      OPCODE_W'(OP_BNE): begin
        ctrl_o.mem.branch = 1'b1;
        ctrl_o.alu_op     = ALUOP_SUB;
      end
      OPCODE_W'(OP_XORI): begin
        ctrl_o.alu_src          = 1'b1;
        ctrl_o.sign_zero        = 1'b1;
        ctrl_o.mem.wb.reg_write = 1'b1;
        ctrl_o.alu_op           = ALUOP_XOR;
      end
      OPCODE_W'(OP_J): begin
        jump_o = 1'b1;
      end
      default: begin
        ctrl_o.alu_op = ALUOP_RTYPE;
`ifdef ILLEGAL_OP_TRAP_EN
        legal_o = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, jump/branch flush and a saturating lost-cycle counter.
// Optional ILLEGAL_OP_TRAP_EN adds a sticky illegal-opcode flag.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int STALL_CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  pipe_ctrl_if.slave  bus
);

  ctrl_bundle_t           decCtrl;
  logic                   decJump;
  logic                   loadUse;
  logic                   stallId;
  logic                   jumpSel;
  ctrl_bundle_t           idexCtrl_d, idexCtrl_q;
  mem_ctrl_t              exmemCtrl_d, exmemCtrl_q;
  wb_ctrl_t               memwbCtrl_q;
  logic [STALL_CNT_W-1:0] stallCnt_q;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                   decLegal;
  logic                   illegalOp_q;
`endif

  pipe_ctrl_decode #(.OPCODE_W(OPCODE_W)) uDecode (
    .opcode_i (bus.id_opcode_i),
    .ctrl_o   (decCtrl),
`ifdef ILLEGAL_OP_TRAP_EN
    .legal_o  (decLegal),
`endif
    .jump_o   (decJump)
  );

  // A taken branch in MEM overrides the stall: the dependent instruction is flushed anyway.
  assign loadUse = idexCtrl_q.mem.mem_read
                && (bus.idex_rt_i != REG_ADDR_W'(0))
                && ((bus.idex_rt_i == bus.id_rs_i) || (bus.idex_rt_i == bus.id_rt_i));
  assign stallId = loadUse && !bus.branch_taken_i;
  assign jumpSel = decJump && !loadUse && !bus.branch_taken_i;

  assign bus.pc_write_o   = !stallId;
  assign bus.ifid_write_o = !stallId;
  assign bus.ifid_flush_o = jumpSel || bus.branch_taken_i;
  assign bus.jump_o       = jumpSel;

  always_comb begin
    idexCtrl_d = decCtrl;
`ifdef ILLEGAL_OP_TRAP_EN
    if (!decLegal) idexCtrl_d = CTRL_BUBBLE;
`endif
    if (bus.branch_taken_i || loadUse) idexCtrl_d = CTRL_BUBBLE;
    exmemCtrl_d = bus.branch_taken_i ? mem_ctrl_t'('0) : idexCtrl_q.mem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idexCtrl_q  <= CTRL_BUBBLE;
      exmemCtrl_q <= '0;
      memwbCtrl_q <= '0;
    end else begin
      idexCtrl_q  <= idexCtrl_d;
      exmemCtrl_q <= exmemCtrl_d;
      memwbCtrl_q <= exmemCtrl_q.wb;
    end
  end

  // Counts every cycle lost to a stall or flush; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
    end else if ((loadUse || jumpSel || bus.branch_taken_i) && (stallCnt_q != '1)) begin
      stallCnt_q <= stallCnt_q + STALL_CNT_W'(1);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegalOp_q <= 1'b0;
    end else if (!decLegal && !loadUse && !bus.branch_taken_i) begin
      illegalOp_q <= 1'b1;
    end
  end

  assign bus.illegal_op_o = illegalOp_q;
`endif

  assign bus.ex_reg_dst_o    = idexCtrl_q.reg_dst;
  assign bus.ex_alu_src_o    = idexCtrl_q.alu_src;
  assign bus.ex_sign_zero_o  = idexCtrl_q.sign_zero;
  assign bus.ex_alu_op_o     = ALUOP_W'(idexCtrl_q.alu_op);
  assign bus.ex_mem_read_o   = idexCtrl_q.mem.mem_read;
  assign bus.mem_mem_read_o  = exmemCtrl_q.mem_read;
  assign bus.mem_mem_write_o = exmemCtrl_q.mem_write;
  assign bus.mem_branch_o    = exmemCtrl_q.branch;
  assign bus.wb_reg_write_o  = memwbCtrl_q.reg_write;
  assign bus.wb_mem_to_reg_o = memwbCtrl_q.mem_to_reg;
  assign bus.stall_cnt_o     = stallCnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a stage-by-stage behavioural model checked
// every negedge, plus hand-computed literal pins. Covers ILLEGAL_OP_TRAP_EN when defined.
module tb_pipe_ctrl_unit;

  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BNE  = 6'b000101;
  localparam logic [5:0] OPC_XORI = 6'b001110;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic reset;

  pipe_ctrl_if #(.OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2), .STALL_CNT_W(CW)) bus ();

  pipe_ctrl_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .ALUOP_W(2), .STALL_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  // Model stage contents, bit order:
  // [9]RegDst [8]ALUSrc [7]SignZero [6:5]ALUOp [4]MemRead [3]MemWrite [2]Branch [1]RegWrite [0]MemtoReg
  logic [9:0] mEx, mMem, mWb;
  int         mCnt;
  bit         mIll;

  function automatic bit isListed(logic [5:0] op);
    return (op == OPC_R) || (op == OPC_LW) || (op == OPC_SW) ||
           (op == OPC_BNE) || (op == OPC_XORI) || (op == OPC_J);
  endfunction

  function automatic logic [9:0] specControls(logic [5:0] op);
    case (op)
      OPC_R:    return 10'b1_0_0_10_0_0_0_1_0;
      OPC_LW:   return 10'b0_1_0_00_1_0_0_1_1;
      OPC_SW:   return 10'b0_1_0_00_0_1_0_0_0;
      OPC_BNE:  return 10'b0_0_0_01_0_0_1_0_0;
      OPC_XORI: return 10'b0_1_1_11_0_0_0_1_0;
      OPC_J:    return 10'b0_0_0_00_0_0_0_0_0;
`ifdef ILLEGAL_OP_TRAP_EN
      default:  return 10'b0_0_0_00_0_0_0_0_0;
`else
      default:  return 10'b0_0_0_10_0_0_0_0_0;
`endif
    endcase
  endfunction

  function automatic bit modelLoadUse();
    return mEx[4] && (bus.idex_rt_i != 5'd0) &&
           ((bus.idex_rt_i == bus.id_rs_i) || (bus.idex_rt_i == bus.id_rt_i));
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                               logic [4:0] idexRt, logic br);
    @(posedge clk);
    #1;
    bus.id_opcode_i    = op;
    bus.id_rs_i        = rs;
    bus.id_rt_i        = rt;
    bus.idex_rt_i      = idexRt;
    bus.branch_taken_i = br;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Model advance: stages shift each edge; branch kills ID/EX and EX/MEM, load-use kills ID/EX.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mEx  = '0;
      mMem = '0;
      mWb  = '0;
      mCnt = 0;
      mIll = 1'b0;
    end else begin
      bit lu, br, jmp;
      lu  = modelLoadUse();
      br  = bus.branch_taken_i;
      jmp = (bus.id_opcode_i == OPC_J) && !lu && !br;
      if ((lu || br || jmp) && (mCnt < CNT_MAX)) mCnt++;
      if (!isListed(bus.id_opcode_i) && !lu && !br) mIll = 1'b1;
      mWb  = mMem;
      mMem = br ? 10'd0 : mEx;
      mEx  = (lu || br) ? 10'd0 : specControls(bus.id_opcode_i);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      bit lu, br, jmp;
      lu  = modelLoadUse();
      br  = bus.branch_taken_i;
      jmp = (bus.id_opcode_i == OPC_J) && !lu && !br;
      checkOutput("pc_write",      32'(bus.pc_write_o),      32'(br || !lu));
      checkOutput("ifid_write",    32'(bus.ifid_write_o),    32'(br || !lu));
      checkOutput("ifid_flush",    32'(bus.ifid_flush_o),    32'(jmp || br));
      checkOutput("jump",          32'(bus.jump_o),          32'(jmp));
      checkOutput("ex_reg_dst",    32'(bus.ex_reg_dst_o),    32'(mEx[9]));
      checkOutput("ex_alu_src",    32'(bus.ex_alu_src_o),    32'(mEx[8]));
      checkOutput("ex_sign_zero",  32'(bus.ex_sign_zero_o),  32'(mEx[7]));
      checkOutput("ex_alu_op",     32'(bus.ex_alu_op_o),     32'(mEx[6:5]));
      checkOutput("ex_mem_read",   32'(bus.ex_mem_read_o),   32'(mEx[4]));
      checkOutput("mem_mem_read",  32'(bus.mem_mem_read_o),  32'(mMem[4]));
      checkOutput("mem_mem_write", 32'(bus.mem_mem_write_o), 32'(mMem[3]));
      checkOutput("mem_branch",    32'(bus.mem_branch_o),    32'(mMem[2]));
      checkOutput("wb_reg_write",  32'(bus.wb_reg_write_o),  32'(mWb[1]));
      checkOutput("wb_mem_to_reg", 32'(bus.wb_mem_to_reg_o), 32'(mWb[0]));
      checkOutput("stall_cnt",     32'(bus.stall_cnt_o),     32'(mCnt));
`ifdef ILLEGAL_OP_TRAP_EN
      checkOutput("illegal_op",    32'(bus.illegal_op_o),    32'(mIll));
`endif
    end
  end

  initial begin
    reset              = 1'b1;
    bus.id_opcode_i    = OPC_R;
    bus.id_rs_i        = '0;
    bus.id_rt_i        = '0;
    bus.idex_rt_i      = '0;
    bus.branch_taken_i = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    checkEn = 1'b1;
    $display("[TB] reset released, starting directed vectors");

    // Back-to-back R, lw, sw, bne, xori: each bundle at ex +1, mem +2, wb +3 edges.
    applyStimulus(OPC_R,    5'd1, 5'd2, 5'd0, 1'b0);
    applyStimulus(OPC_LW,   5'd1, 5'd7, 5'd2, 1'b0);
    applyStimulus(OPC_SW,   5'd3, 5'd4, 5'd7, 1'b0);
    applyStimulus(OPC_BNE,  5'd5, 5'd6, 5'd4, 1'b0);
    applyStimulus(OPC_XORI, 5'd8, 5'd9, 5'd6, 1'b0);
    #2;
    checkOutput("lit_ex_alu_op_bne",   32'(bus.ex_alu_op_o),     32'd1);
    checkOutput("lit_mem_write_sw",    32'(bus.mem_mem_write_o), 32'd1);
    checkOutput("lit_wb_memtoreg_lw",  32'(bus.wb_mem_to_reg_o), 32'd1);
    checkOutput("lit_wb_regwrite_lw",  32'(bus.wb_reg_write_o),  32'd1);
    applyStimulus(OPC_R, 5'd10, 5'd11, 5'd9, 1'b0);
    #2;
    checkOutput("lit_ex_alu_op_xori",  32'(bus.ex_alu_op_o),     32'd3);
    checkOutput("lit_ex_signzero_xori",32'(bus.ex_sign_zero_o),  32'd1);
    checkOutput("lit_mem_branch_bne",  32'(bus.mem_branch_o),    32'd1);
    checkOutput("lit_wb_regwrite_sw",  32'(bus.wb_reg_write_o),  32'd0);

    // Load-use: lw rt=5 then R rs=5 stalls exactly one cycle.
    doReset();
    applyStimulus(OPC_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    applyStimulus(OPC_R,  5'd5, 5'd2, 5'd5, 1'b0);
    #2;
    checkOutput("lit_lu_pc_write",     32'(bus.pc_write_o),      32'd0);
    checkOutput("lit_lu_ifid_write",   32'(bus.ifid_write_o),    32'd0);
    applyStimulus(OPC_R,  5'd5, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_lu_stall_cnt",    32'(bus.stall_cnt_o),     32'd1);
    checkOutput("lit_lu_ex_bubble",    32'(bus.ex_mem_read_o),   32'd0);
    checkOutput("lit_lu_mem_lw",       32'(bus.mem_mem_read_o),  32'd1);
    checkOutput("lit_lu_resume",       32'(bus.pc_write_o),      32'd1);

    // Same sequence with rt=0: register 0 never creates a hazard.
    doReset();
    applyStimulus(OPC_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    applyStimulus(OPC_R,  5'd0, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_r0_pc_write",     32'(bus.pc_write_o),      32'd1);
    applyStimulus(OPC_R,  5'd3, 5'd4, 5'd2, 1'b0);
    #2;
    checkOutput("lit_r0_stall_cnt",    32'(bus.stall_cnt_o),     32'd0);
    checkOutput("lit_r0_ex_reg_dst",   32'(bus.ex_reg_dst_o),    32'd1);

    // Jump flushes IF/ID for one cycle and counts one lost cycle.
    doReset();
    applyStimulus(OPC_J, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    checkOutput("lit_j_jump",          32'(bus.jump_o),          32'd1);
    checkOutput("lit_j_flush",         32'(bus.ifid_flush_o),    32'd1);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_j_jump_off",      32'(bus.jump_o),          32'd0);
    checkOutput("lit_j_stall_cnt",     32'(bus.stall_cnt_o),     32'd1);
    checkOutput("lit_j_ex_alu_op",     32'(bus.ex_alu_op_o),     32'd0);

    // Taken branch while load-use is also true: branch wins, no stall, bubbles in EX and MEM.
    doReset();
    applyStimulus(OPC_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    applyStimulus(OPC_R,  5'd5, 5'd2, 5'd5, 1'b1);
    #2;
    checkOutput("lit_br_flush",        32'(bus.ifid_flush_o),    32'd1);
    checkOutput("lit_br_pc_write",     32'(bus.pc_write_o),      32'd1);
    checkOutput("lit_br_ifid_write",   32'(bus.ifid_write_o),    32'd1);
    applyStimulus(OPC_R,  5'd5, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_br_ex_bubble",    32'(bus.ex_reg_dst_o),    32'd0);
    checkOutput("lit_br_mem_bubble",   32'(bus.mem_mem_read_o),  32'd0);
    checkOutput("lit_br_stall_cnt",    32'(bus.stall_cnt_o),     32'd1);

    // Asynchronous reset mid-cycle with lw sitting in EX.
    applyStimulus(OPC_LW, 5'd1, 5'd6, 5'd0, 1'b0);
    applyStimulus(OPC_R,  5'd2, 5'd3, 5'd6, 1'b0);
    #2;
    checkOutput("lit_pre_rst_ex_lw",   32'(bus.ex_mem_read_o),   32'd1);
    reset = 1'b1;
    #1;
    checkOutput("lit_rst_ex_mem_read", 32'(bus.ex_mem_read_o),   32'd0);
    checkOutput("lit_rst_ex_alu_op",   32'(bus.ex_alu_op_o),     32'd0);
    checkOutput("lit_rst_mem_read",    32'(bus.mem_mem_read_o),  32'd0);
    checkOutput("lit_rst_wb_regwrite", 32'(bus.wb_reg_write_o),  32'd0);
    checkOutput("lit_rst_stall_cnt",   32'(bus.stall_cnt_o),     32'd0);
    checkOutput("lit_rst_pc_write",    32'(bus.pc_write_o),      32'd1);
    checkOutput("lit_rst_flush",       32'(bus.ifid_flush_o),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 2^4+3 consecutive jumps: counter must hold at 15.
    for (int i = 0; i < 19; i++) applyStimulus(OPC_J, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_sat_stall_cnt",   32'(bus.stall_cnt_o),     32'd15);

    // Unlisted opcode handling.
    doReset();
    applyStimulus(OPC_BAD, 5'd1, 5'd2, 5'd0, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    #2;
    checkOutput("lit_ill_before",      32'(bus.illegal_op_o),    32'd0);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_ill_set",         32'(bus.illegal_op_o),    32'd1);
    checkOutput("lit_ill_ex_bubble",   32'(bus.ex_alu_op_o),     32'd0);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_ill_sticky",      32'(bus.illegal_op_o),    32'd1);
    reset = 1'b1;
    #1;
    checkOutput("lit_ill_cleared",     32'(bus.illegal_op_o),    32'd0);
    @(negedge clk);
    reset = 1'b0;
`else
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    #2;
    checkOutput("lit_def_ex_alu_op",   32'(bus.ex_alu_op_o),     32'd2);
    checkOutput("lit_def_ex_reg_dst",  32'(bus.ex_reg_dst_o),    32'd0);
`endif

    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    applyStimulus(OPC_R, 5'd1, 5'd2, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
